// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: host-side initiator of the NoC UART control protocol, with byte-level UART tx/rx.
// Revision 1.0
`default_nettype none

module transmitter #(
    parameter int BAUD_RATE = 100_000_000,
    parameter int CLK_FREQ  = 1_000_000_000
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       tx_o
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

    logic [9:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [31:0] baud_cnt;
    logic        busy;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            shreg    <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            busy     <= 1'b0;
        end else if (!busy) begin
            if (data_valid_i) begin
                shreg    <= {1'b1, data_i, 1'b0};
                bit_cnt  <= '0;
                baud_cnt <= '0;
                busy     <= 1'b1;
            end
        end else if (baud_cnt == 32'(BIT_CYCLES - 1)) begin
            baud_cnt <= '0;
            shreg    <= {1'b1, shreg[9:1]};
            if (bit_cnt == 4'd9) busy <= 1'b0;
            else                 bit_cnt <= bit_cnt + 4'd1;
        end else begin
            baud_cnt <= baud_cnt + 32'd1;
        end
    end

    assign data_ready_o = !busy;
    assign tx_o         = busy ? shreg[0] : 1'b1;
endmodule

module receiver #(
    parameter int BAUD_RATE = 100_000_000,
    parameter int CLK_FREQ  = 1_000_000_000
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    input  logic       data_ready_i
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

    logic [1:0]  sync;
    logic [7:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [31:0] baud_cnt;
    logic        busy;
    logic        valid;
    logic [31:0] target;

    // The start bit is sampled half a bit in; every later bit a full bit after the previous sample.
    assign target = (bit_cnt == 4'd0) ? 32'(BIT_CYCLES / 2 - 1) : 32'(BIT_CYCLES - 1);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync     <= '1;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            sync  <= {sync[0], rx_i};
            valid <= valid && !data_ready_i;
            if (!busy) begin
                if (!sync[1]) begin
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
                end
            end else if (baud_cnt == target) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (sync[1]) busy <= 1'b0;
                    else         bit_cnt <= 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    busy <= 1'b0;
                    if (sync[1]) valid <= 1'b1;
                end else begin
                    shreg   <= {sync[1], shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 32'd1;
            end
        end
    end

    assign data_o       = shreg;
    assign data_valid_o = valid;
endmodule

module uart_host_ctrl #(
    parameter int CORE_COUNT     = 16,
    parameter int AXI_ID_WIDTH   = 5,
    parameter int BAUD_RATE      = 100_000_000,
    parameter int CLK_FREQ       = 1_000_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic                          rx_i,
    output logic                          tx_o,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [3:0]                    cmd_op_i,
    input  logic [$clog2(CORE_COUNT)-1:0] cmd_core_i,
    input  logic [AXI_ID_WIDTH-1:0]       cmd_id_i,
    input  logic [7:0]                    cmd_arg_i,
    output logic                          rsp_valid_o,
    output logic [63:0]                   rsp_data_o,
    output logic                          rsp_timeout_o,
    output logic                          rsp_err_o,
    output logic                          stray_rx_o
);
    localparam int CORE_W           = $clog2(CORE_COUNT);
    localparam int CORE_COUNT_BYTES = (CORE_W + 7) / 8;
    localparam int AXI_ID_BYTES     = (AXI_ID_WIDTH + 7) / 8;
    localparam int IDLE_BYTES       = CORE_COUNT / 8;
    localparam int TXB              = 2 + CORE_COUNT_BYTES + AXI_ID_BYTES;

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
    state_t state, state_next;

    logic [8*TXB-1:0] tx_buf, new_buf;
    logic [7:0]       tx_len, new_tx_len, tx_idx;
    logic [7:0]       rx_len, new_rx_len, rx_idx;
    logic [31:0]      tmo_cnt;
    logic             tx_valid, tx_ready, legal;
    logic [7:0]       tx_byte, rx_byte, op_byte;
    logic             rx_valid;
    logic [8*CORE_COUNT_BYTES-1:0] core_ext;
    logic [8*AXI_ID_BYTES-1:0]     id_ext;
    logic             accept, tx_hs, tx_last, rx_got, rx_last, tmo_hit;

    assign op_byte  = {4'h0, cmd_op_i};
    assign core_ext = (8*CORE_COUNT_BYTES)'(cmd_core_i);
    assign id_ext   = (8*AXI_ID_BYTES)'(cmd_id_i);

    // Whole command frame is packed LSB-first at accept; tx_idx then just walks it.
    always_comb begin
        new_buf    = '0;
        new_tx_len = 8'd1;
        new_rx_len = 8'd0;
        legal      = 1'b1;
        case (cmd_op_i)
            4'd1: begin
                new_buf = {{(8*(TXB-2)){1'b0}}, cmd_arg_i, op_byte};
                new_tx_len = 8'd2;
                new_rx_len = 8'd1;
            end
            4'd2: begin
                new_buf = {{(8*(TXB-2)){1'b0}}, cmd_arg_i, op_byte};
                new_tx_len = 8'd2;
            end
            4'd3, 4'd4: begin
                new_buf = {cmd_arg_i, id_ext, core_ext, op_byte};
                new_tx_len = 8'(TXB);
            end
            4'd5: begin
                new_buf = {{(8*(TXB-1)){1'b0}}, op_byte};
                new_rx_len = 8'(IDLE_BYTES);
            end
            4'd6: new_buf = {{(8*(TXB-1)){1'b0}}, op_byte};
            4'd7: begin
                new_buf = {{(8*AXI_ID_BYTES){1'b0}}, 3'b000, cmd_arg_i[4:0], core_ext, op_byte};
                new_tx_len = 8'(2 + CORE_COUNT_BYTES);
                new_rx_len = 8'd8;
            end
            4'd8: begin
                new_buf = {{(8*(TXB-1)){1'b0}}, op_byte};
                new_rx_len = 8'd1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign accept  = cmd_valid_i && (state == IDLE);
    assign tx_hs   = tx_valid && tx_ready;
    assign tx_last = (tx_idx == tx_len - 8'd1);
    assign rx_got  = rx_valid && (state == RECV);
    assign rx_last = (rx_idx == rx_len - 8'd1);
    assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES));
    assign tx_byte = 8'(tx_buf >> {tx_idx, 3'b000});

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (accept) state_next = legal ? SEND : DONE;
            end
            SEND: if (tx_hs && tx_last) state_next = (rx_len != 8'd0) ? RECV : DONE;
            RECV: begin
                if (rx_got) begin
                    if (rx_last) state_next = DONE;
                end else if (tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid_o = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            tx_buf        <= '0;
            tx_len        <= '0;
            rx_len        <= '0;
            tx_idx        <= '0;
            rx_idx        <= '0;
            tx_valid      <= 1'b0;
            tmo_cnt       <= '0;
            rsp_data_o    <= '0;
            rsp_timeout_o <= 1'b0;
            rsp_err_o     <= 1'b0;
            stray_rx_o    <= 1'b0;
        end else begin
            if (accept) begin
                tx_buf        <= new_buf;
                tx_len        <= new_tx_len;
                rx_len        <= new_rx_len;
                tx_idx        <= '0;
                rx_idx        <= '0;
                tx_valid      <= legal;
                tmo_cnt       <= '0;
                rsp_data_o    <= '0;
                rsp_timeout_o <= 1'b0;
                rsp_err_o     <= !legal;
                stray_rx_o    <= 1'b0;
            end
            if (state == SEND && tx_hs) begin
                if (tx_last) begin
                    tx_valid <= 1'b0;
                    tmo_cnt  <= '0;
                end else begin
                    tx_idx <= tx_idx + 8'd1;
                end
            end
            // A byte landing on the timeout cycle wins over the timeout.
            if (state == RECV) begin
                if (rx_got) begin
                    rsp_data_o[{rx_idx[2:0], 3'b000} +: 8] <= rx_byte;
                    rx_idx  <= rx_idx + 8'd1;
                    tmo_cnt <= '0;
                end else if (tmo_hit) begin
                    rsp_timeout_o <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end
            if (rx_valid && state != RECV) stray_rx_o <= 1'b1;
        end
    end

    transmitter #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ)) u_tx (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .data_i       (tx_byte),
        .data_valid_i (tx_valid),
        .data_ready_o (tx_ready),
        .tx_o         (tx_o)
    );

    receiver #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ)) u_rx (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .rx_i         (rx_i),
        .data_o       (rx_byte),
        .data_valid_o (rx_valid),
        .data_ready_i (1'b1)
    );
endmodule

`default_nettype wire

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: loopback bench with a behavioural chip-side responder on tx_o/rx_i.
`timescale 1ns/1ps
module tb_uart_host_ctrl;
    localparam int CORE_COUNT = 16;
    localparam int AXI_ID_WIDTH = 5;
    localparam int TIMEOUT = 600;
    localparam int BIT_CLKS = 10;
    localparam int CCB = 1;
    localparam int AIB = 1;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic rx = 1'b1;
    logic tx;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [3:0] cmd_core = '0;
    logic [4:0] cmd_id = '0;
    logic [7:0] cmd_arg = '0;
    logic rsp_valid;
    logic [63:0] rsp_data;
    logic rsp_timeout, rsp_err, stray_rx;

    uart_host_ctrl #(
        .CORE_COUNT(CORE_COUNT), .AXI_ID_WIDTH(AXI_ID_WIDTH),
        .BAUD_RATE(100), .CLK_FREQ(1000), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i(clk), .arstn_i(arstn), .rx_i(rx), .tx_o(tx),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_core_i(cmd_core), .cmd_id_i(cmd_id), .cmd_arg_i(cmd_arg),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .rsp_timeout_o(rsp_timeout), .rsp_err_o(rsp_err), .stray_rx_o(stray_rx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cycle = 0;
    int rsp_cnt = 0;
    int cap_cycle = 0;
    logic [63:0] cap_data;
    logic cap_to, cap_err, cap_ready;
    logic [7:0] tx_seen[$];
    logic [7:0] exp_tx[$];

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  core;
        logic [4:0]  id;
        logic [7:0]  arg;
        logic [63:0] rsp;
        int          nsend;
        logic [63:0] exp_data;
        logic        exp_to;
        logic        exp_err;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_cnt   <= rsp_cnt + 1;
            cap_cycle <= cycle;
            cap_data  <= rsp_data;
            cap_to    <= rsp_timeout;
            cap_err   <= rsp_err;
            cap_ready <= cmd_ready;
        end
    end

    // Chip-side byte decoder watching tx_o.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (arstn && tx === 1'b0) begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT_CLKS) @(negedge clk);
                tx_seen.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) rx = 1'b0;
        repeat (BIT_CLKS - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx = b[i];
            repeat (BIT_CLKS - 1) @(negedge clk);
        end
        @(negedge clk) rx = 1'b1;
        repeat (BIT_CLKS + 2) @(negedge clk);
    endtask

    function automatic int resp_len(input logic [3:0] op);
        case (op)
            4'd1, 4'd8: return 1;
            4'd5:       return CORE_COUNT / 8;
            4'd7:       return 8;
            default:    return 0;
        endcase
    endfunction

    task automatic model_tx(input logic [3:0] op, input logic [3:0] core,
                            input logic [4:0] id, input logic [7:0] arg);
        exp_tx.delete();
        if (op == 0 || op > 8) return;
        exp_tx.push_back(8'(op));
        if (op == 1 || op == 2) exp_tx.push_back(arg);
        if (op == 3 || op == 4 || op == 7)
            for (int k = 0; k < CCB; k++) exp_tx.push_back(8'(32'(core) >> (8 * k)));
        if (op == 3 || op == 4) begin
            for (int k = 0; k < AIB; k++) exp_tx.push_back(8'(32'(id) >> (8 * k)));
            exp_tx.push_back(arg);
        end
        if (op == 7) exp_tx.push_back(arg % 32);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] core, input logic [4:0] id,
                           input logic [7:0] arg, input logic [63:0] rsp, input int nsend,
                           input logic [63:0] exp_data, input logic exp_to, input logic exp_err);
        int k, start, acc;
        logic tx_idle;
        model_tx(op, core, id, arg);
        tx_seen.delete();
        k = 0;
        while (cmd_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        check("ready_before_cmd", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_op = op; cmd_core = core; cmd_id = id; cmd_arg = arg; cmd_valid = 1'b1;
        start = rsp_cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = cycle;
        k = 0;
        while (tx_seen.size() < exp_tx.size() && k < 2000) begin @(negedge clk); k++; end
        check("tx_byte_count", 64'(tx_seen.size()), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
            check("tx_byte", 64'(tx_seen[i]), 64'(exp_tx[i]));
        for (int i = 0; i < nsend; i++) send_byte(rsp[8*i +: 8]);
        k = 0;
        while (rsp_cnt == start && k < 4000) begin @(negedge clk); k++; end
        @(negedge clk);
        check("rsp_pulse_count", 64'(rsp_cnt - start), 64'd1);
        check("ready_after_pulse", 64'(cmd_ready), 64'd1);
        check("ready_low_at_pulse", 64'(cap_ready), 64'd0);
        check("rsp_data", cap_data, exp_data);
        check("rsp_timeout", 64'(cap_to), 64'(exp_to));
        check("rsp_err", 64'(cap_err), 64'(exp_err));
        check("stray_rx", 64'(stray_rx), 64'd0);
        if (exp_err) begin
            check("err_latency", 64'(cap_cycle - acc), 64'd0);
            tx_idle = 1'b1;
            repeat (30) begin @(negedge clk); if (tx !== 1'b1) tx_idle = 1'b0; end
            check("tx_idle_on_err", 64'(tx_idle), 64'd1);
        end
    endtask

    initial begin
        logic [3:0] op;
        logic [63:0] rsp, expd;
        int r, ns, start;

        vecs[0]  = '{4'd1, 4'd0, 5'h00, 8'h41, 64'h42, 1, 64'h42, 1'b0, 1'b0};
        vecs[1]  = '{4'd2, 4'd0, 5'h00, 8'h10, 64'h0, 0, 64'h0, 1'b0, 1'b0};
        vecs[2]  = '{4'd3, 4'd5, 5'h1A, 8'h03, 64'h0, 0, 64'h0, 1'b0, 1'b0};
        vecs[3]  = '{4'd7, 4'd2, 5'h00, 8'h04, 64'h0123456789ABCDEF, 8, 64'h0123456789ABCDEF, 1'b0, 1'b0};
        vecs[4]  = '{4'd5, 4'd0, 5'h00, 8'h00, 64'hA5C3, 2, 64'hA5C3, 1'b0, 1'b0};
        vecs[5]  = '{4'd8, 4'd0, 5'h00, 8'h00, 64'h08, 1, 64'h08, 1'b0, 1'b0};
        vecs[6]  = '{4'd1, 4'd0, 5'h00, 8'h7F, 64'h0, 0, 64'h0, 1'b1, 1'b0};
        vecs[7]  = '{4'hC, 4'd0, 5'h00, 8'h00, 64'h0, 0, 64'h0, 1'b0, 1'b1};
        vecs[8]  = '{4'h0, 4'd3, 5'h01, 8'h55, 64'h0, 0, 64'h0, 1'b0, 1'b1};
        vecs[9]  = '{4'd7, 4'd9, 5'h00, 8'hFF, 64'h1122334455667788, 3, 64'h667788, 1'b1, 1'b0};
        vecs[10] = '{4'd4, 4'hF, 5'h1F, 8'h80, 64'h0, 0, 64'h0, 1'b0, 1'b0};
        vecs[11] = '{4'd6, 4'd0, 5'h00, 8'h00, 64'h0, 0, 64'h0, 1'b0, 1'b0};
        vecs[12] = '{4'd9, 4'd0, 5'h00, 8'h00, 64'h0, 0, 64'h0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_ready", 64'(cmd_ready), 64'd1);
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_data", rsp_data, 64'd0);
        check("reset_flags", {61'd0, rsp_timeout, rsp_err, stray_rx}, 64'd0);
        check("reset_tx", 64'(tx), 64'd1);
        arstn = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vecs[i])
            run_cmd(vecs[i].op, vecs[i].core, vecs[i].id, vecs[i].arg, vecs[i].rsp,
                    vecs[i].nsend, vecs[i].exp_data, vecs[i].exp_to, vecs[i].exp_err);

        // Byte arriving while idle is dropped and flagged; the next accept clears the flag.
        send_byte(8'h5A);
        repeat (5) @(negedge clk);
        check("stray_set_in_idle", 64'(stray_rx), 64'd1);
        run_cmd(4'd2, 4'd0, 5'd0, 8'h33, 64'd0, 0, 64'd0, 1'b0, 1'b0);

        // Reset in the middle of an op7 SEND.
        @(negedge clk);
        cmd_op = 4'd7; cmd_core = 4'd2; cmd_arg = 8'h04; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        start = rsp_cnt;
        repeat (150) @(negedge clk);
        #2 arstn = 1'b0;
        #1;
        check("midreset_ready", 64'(cmd_ready), 64'd1);
        check("midreset_valid", 64'(rsp_valid), 64'd0);
        check("midreset_data", rsp_data, 64'd0);
        check("midreset_flags", {61'd0, rsp_timeout, rsp_err, stray_rx}, 64'd0);
        check("midreset_tx", 64'(tx), 64'd1);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        repeat (150) @(negedge clk);
        check("midreset_no_pulse", 64'(rsp_cnt - start), 64'd0);
        run_cmd(4'd1, 4'd0, 5'd0, 8'h41, 64'h42, 1, 64'h42, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
            rsp = {$urandom, $urandom};
            r = resp_len(op);
            ns = r;
            if (r > 0 && $urandom_range(0, 7) == 0) ns = $urandom_range(0, r - 1);
            expd = '0;
            for (int k = 0; k < ns; k++) expd[8*k +: 8] = rsp[8*k +: 8];
            run_cmd(op, 4'($urandom), 5'($urandom), 8'($urandom), rsp, ns, expd,
                    (op >= 1 && op <= 8) && (ns < r), !(op >= 1 && op <= 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
